// File: rtl/ooo_types_pkg.sv
// rtl/ooo_types_pkg.sv - shared fetch-side types and constants
package ooo_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

  // Fetch addresses are word aligned; the low bits of a redirect target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and imem requester feeding the instruction queue
module fetch_unit
  import ooo_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IQ_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  output logic [31:0]         imem_addr,
  output logic [3:0]          imem_rmask,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_resp,
  input  logic                iq_full,
  output logic                iq_push,
  output logic [IQ_WIDTH-1:0] iq_wdata,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         req_live;
  logic         accept;
  iq_entry_t    entry;

  // REQ only exposes the request once the queue has room, so an issued request
  // always has a free slot waiting for its response.
  always_comb begin
    req_live    = (state == WAIT) || (state == DISCARD) || ((state == REQ) && !iq_full);
    accept      = req_live && (state != DISCARD) && imem_resp && !redirect_valid;
    entry.pc    = pc;
    entry.instr = imem_rdata;
  end

  assign imem_addr  = pc;
  assign imem_rmask = req_live ? 4'hF : 4'h0;
  assign iq_push    = accept;
  assign iq_wdata   = accept ? IQ_WIDTH'(entry) : '0;

  // Fetch FSM and PC register; a redirect always wins over the response in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= align_pc(redirect_pc);
          end else if (!iq_full) begin
            state <= REQ;
          end
        end
        REQ, WAIT: begin
          if ((state == REQ) && iq_full) begin
            // No request was exposed, so there is nothing to discard.
            if (redirect_valid) pc <= align_pc(redirect_pc);
            state <= IDLE;
          end else if (redirect_valid) begin
            pc    <= align_pc(redirect_pc);
            state <= imem_resp ? IDLE : DISCARD;
          end else if (imem_resp) begin
            pc    <= pc + 32'd4;
            state <= iq_full ? IDLE : REQ;
          end else begin
            state <= WAIT;
          end
        end
        DISCARD: begin
          if (redirect_valid) pc <= align_pc(redirect_pc);
          if (imem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
